// File: rtl/dijkstra_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dijkstra_pkg
// Brief    : Shared widths, edge-word field offsets, error codes and builder
//            state encoding for the shortest-path engine.
// Revision : 1.0
// ============================================================================
package dijkstra_pkg;

    localparam int NODE_W  = 4;
    localparam int WGT_W   = 4;
    localparam int MAX_DEG = 8;
    localparam int DEG_W   = 4;

    localparam int EDGE_W     = 12;
    localparam int PARENT_LSB = 0;
    localparam int CHILD_LSB  = 4;
    localparam int WGT_LSB    = 8;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_NODE = 2'd1;
    localparam logic [1:0] ERR_DEG  = 2'd2;
    localparam logic [1:0] ERR_N    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/edge_adj_builder_if.sv
`default_nettype none
// ============================================================================
// Interface: edge_adj_builder_if
// Brief    : Valid/ready stream of packed {weight, child, parent} edge words.
// Revision : 1.0
// ============================================================================
interface edge_adj_builder_if;
    logic                            edge_valid;
    logic                            edge_ready;
    logic [dijkstra_pkg::EDGE_W-1:0] edge_data;

    modport master (output edge_valid, output edge_data, input edge_ready);
    modport slave  (input edge_valid, input edge_data, output edge_ready);
endinterface
`default_nettype wire

// File: rtl/edge_adj_builder_adj_row.sv
`default_nettype none
// ============================================================================
// Module   : adj_row
// Brief    : One node's adjacency list: append-at-degree write, degree
//            counter and zero-filled indexed read.
// Revision : 1.0
// ============================================================================
module adj_row #(
    parameter int NODE_W  = 4,
    parameter int WGT_W   = 4,
    parameter int MAX_DEG = 8,
    parameter int DEG_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [NODE_W-1:0] wr_nbr,
    input  logic [WGT_W-1:0]  wr_wgt,
    input  logic [DEG_W-1:0]  rd_idx,
    output logic [DEG_W-1:0]  deg,
    output logic [NODE_W-1:0] rd_nbr,
    output logic [WGT_W-1:0]  rd_wgt,
    output logic              rd_hit
);
    localparam int IDX_W = (MAX_DEG > 1) ? $clog2(MAX_DEG) : 1;

    logic [DEG_W-1:0]  r_deg;
    logic [NODE_W-1:0] r_nbr [MAX_DEG];
    logic [WGT_W-1:0]  r_wgt [MAX_DEG];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_deg <= '0;
        end else if (clr) begin
            r_deg <= '0;
        end else if (wr_en) begin
            r_deg <= r_deg + 1'b1;
        end
    end

    // Slots at or above the degree are never exposed, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_nbr[r_deg[IDX_W-1:0]] <= wr_nbr;
            r_wgt[r_deg[IDX_W-1:0]] <= wr_wgt;
        end
    end

    assign deg    = r_deg;
    assign rd_hit = (rd_idx < r_deg);
    assign rd_nbr = rd_hit ? r_nbr[rd_idx[IDX_W-1:0]] : '0;
    assign rd_wgt = rd_hit ? r_wgt[rd_idx[IDX_W-1:0]] : '0;

endmodule
`default_nettype wire

// File: rtl/edge_adj_builder.sv
`default_nettype none
// ============================================================================
// Module   : edge_adj_builder
// Brief    : Validates a streamed edge list and builds per-node adjacency
//            tables with a registered random-access read port.
// Config   : ADJ_BUILDER_DIRECTED_EN - directed lists (default undirected)
// Revision : 1.0
// ============================================================================
module edge_adj_builder #(
    parameter int NODES   = 16,
    parameter int NODE_W  = dijkstra_pkg::NODE_W,
    parameter int WGT_W   = dijkstra_pkg::WGT_W,
    parameter int MAX_DEG = dijkstra_pkg::MAX_DEG,
    parameter int DEG_W   = dijkstra_pkg::DEG_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NODE_W:0]         n,
    input  logic [7:0]              e,
    edge_adj_builder_if.slave       edge_if,
    output logic                    busy,
    output logic                    done,
    output logic                    tables_valid,
    output logic                    err,
    output logic [1:0]              err_code,
    input  logic [NODE_W-1:0]       rd_node,
    input  logic [DEG_W-1:0]        rd_idx,
    output logic [NODE_W-1:0]       rd_nbr,
    output logic [WGT_W-1:0]        rd_wgt,
    output logic [DEG_W-1:0]        rd_deg,
    output logic                    rd_hit
);
    import dijkstra_pkg::*;

    localparam logic [NODE_W:0]  c_nodes   = (NODE_W+1)'(NODES);
    localparam logic [DEG_W-1:0] c_max_deg = DEG_W'(MAX_DEG);

    state_t            r_state, w_state_nx;
    logic [NODE_W:0]   r_n;
    logic [7:0]        r_e, r_cnt, w_cnt_nx;
    logic              r_done;
    logic [1:0]        r_err_code, w_err_code_nx;
    logic              w_latch, w_clr, w_wr_ok, w_accept;
    logic              w_range_bad, w_ovf, w_store;
    logic [NODE_W-1:0] w_parent, w_child;
    logic [WGT_W-1:0]  w_wgt;

    logic [DEG_W-1:0]  w_deg     [NODES];
    logic [NODE_W-1:0] w_row_nbr [NODES];
    logic [WGT_W-1:0]  w_row_wgt [NODES];
    logic              w_row_hit [NODES];

    assign w_parent    = edge_if.edge_data[PARENT_LSB +: NODE_W];
    assign w_child     = edge_if.edge_data[CHILD_LSB  +: NODE_W];
    assign w_wgt       = edge_if.edge_data[WGT_LSB    +: WGT_W];
    assign w_range_bad = ({1'b0, w_parent} >= r_n) || ({1'b0, w_child} >= r_n);
    assign w_cnt_nx    = r_cnt + 8'd1;

`ifdef ADJ_BUILDER_DIRECTED_EN
    assign w_ovf   = (w_deg[w_parent] == c_max_deg);
    assign w_store = 1'b1;
`else
    // A self-loop is counted but never stored, so it cannot overflow a list.
    logic w_self;
    assign w_self  = (w_parent == w_child);
    assign w_ovf   = !w_self && ((w_deg[w_parent] == c_max_deg) ||
                                 (w_deg[w_child]  == c_max_deg));
    assign w_store = !w_self;
`endif

    always_comb begin
        w_state_nx    = r_state;
        w_err_code_nx = r_err_code;
        w_latch       = 1'b0;
        w_clr         = 1'b0;
        w_wr_ok       = 1'b0;
        w_accept      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_latch = 1'b1;
                    if ((n == '0) || (n > c_nodes)) begin
                        w_state_nx    = ST_ERR;
                        w_err_code_nx = ERR_N;
                    end else begin
                        w_state_nx    = ST_CLEAR;
                        w_err_code_nx = ERR_NONE;
                    end
                end
            end
            ST_CLEAR: begin
                w_clr      = 1'b1;
                w_state_nx = (r_e == 8'd0) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                if (edge_if.edge_valid) begin
                    if (w_range_bad) begin
                        w_state_nx    = ST_ERR;
                        w_err_code_nx = ERR_NODE;
                    end else if (w_ovf) begin
                        w_state_nx    = ST_ERR;
                        w_err_code_nx = ERR_DEG;
                    end else begin
                        w_wr_ok  = w_store;
                        w_accept = 1'b1;
                        if (w_cnt_nx == r_e) begin
                            w_state_nx = ST_DONE;
                        end
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_n        <= '0;
            r_e        <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_state_nx;
            r_err_code <= w_err_code_nx;
            r_done     <= (w_state_nx == ST_DONE) && (r_state != ST_DONE);
            if (w_latch) begin
                r_n <= n;
                r_e <= e;
            end
            if (w_clr) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= w_cnt_nx;
            end
        end
    end

    assign edge_if.edge_ready = (r_state == ST_LOAD);
    assign busy               = (r_state == ST_CLEAR) || (r_state == ST_LOAD);
    assign tables_valid       = (r_state == ST_DONE);
    assign err                = (r_state == ST_ERR);
    assign err_code           = r_err_code;
    assign done               = r_done;

    for (genvar gi = 0; gi < NODES; gi++) begin : g_row
        logic              w_is_parent, w_we;
        logic [NODE_W-1:0] w_wr_nbr;
        assign w_is_parent = (w_parent == NODE_W'(gi));
`ifdef ADJ_BUILDER_DIRECTED_EN
        assign w_we     = w_wr_ok && w_is_parent;
        assign w_wr_nbr = w_child;
`else
        assign w_we     = w_wr_ok && (w_is_parent || (w_child == NODE_W'(gi)));
        assign w_wr_nbr = w_is_parent ? w_child : w_parent;
`endif
        adj_row #(
            .NODE_W (NODE_W),
            .WGT_W  (WGT_W),
            .MAX_DEG(MAX_DEG),
            .DEG_W  (DEG_W)
        ) u_row (
            .clk   (clk),
            .reset (reset),
            .clr   (w_clr),
            .wr_en (w_we),
            .wr_nbr(w_wr_nbr),
            .wr_wgt(w_wgt),
            .rd_idx(rd_idx),
            .deg   (w_deg[gi]),
            .rd_nbr(w_row_nbr[gi]),
            .rd_wgt(w_row_wgt[gi]),
            .rd_hit(w_row_hit[gi])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_nbr <= '0;
            rd_wgt <= '0;
            rd_deg <= '0;
            rd_hit <= 1'b0;
        end else if ({1'b0, rd_node} < c_nodes) begin
            rd_nbr <= w_row_nbr[rd_node];
            rd_wgt <= w_row_wgt[rd_node];
            rd_deg <= w_deg[rd_node];
            rd_hit <= w_row_hit[rd_node];
        end else begin
            rd_nbr <= '0;
            rd_wgt <= '0;
            rd_deg <= '0;
            rd_hit <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_edge_adj_builder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_edge_adj_builder
// Brief    : Self-checking bench for edge_adj_builder (directed build when
//            ADJ_BUILDER_DIRECTED_EN is defined).
// Revision : 1.0
// ============================================================================
module tb_edge_adj_builder;
`ifdef ADJ_BUILDER_DIRECTED_EN
    localparam bit DIRECTED = 1'b1;
`else
    localparam bit DIRECTED = 1'b0;
`endif

    typedef struct {
        int n; int e; int mode;
        logic [8:0][11:0] ed;
        int exp_err; int exp_code; int exp_cyc;
        int sp_node; int sp_idx; int sp_nbr; int sp_wgt; int sp_deg; int sp_hit;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [4:0] n = '0;
    logic [7:0] e = '0;
    logic [3:0] rd_node = '0;
    logic [3:0] rd_idx = '0;
    logic       busy, done, tables_valid, err, rd_hit;
    logic [1:0] err_code;
    logic [3:0] rd_nbr, rd_wgt, rd_deg;

    edge_adj_builder_if eif();

    always #5 clk = ~clk;

    edge_adj_builder dut (
        .clk(clk), .reset(reset), .start(start), .n(n), .e(e), .edge_if(eif),
        .busy(busy), .done(done), .tables_valid(tables_valid), .err(err),
        .err_code(err_code), .rd_node(rd_node), .rd_idx(rd_idx),
        .rd_nbr(rd_nbr), .rd_wgt(rd_wgt), .rd_deg(rd_deg), .rd_hit(rd_hit)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_nbr [16][$];
    int          m_wgt [16][$];
    int          m_err, m_code, m_used;
    logic [11:0] g_edges [$];
    vec_t        vecs [11];

    function automatic void chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endfunction

    function automatic logic [11:0] mk(input int p, input int c, input int w);
        logic [11:0] r;
        r = {w[3:0], c[3:0], p[3:0]};
        return r;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) begin
            m_nbr[i].delete();
            m_wgt[i].delete();
        end
    endfunction

    // Reference: walk the edge list applying the builder's acceptance rules.
    function automatic void model_build(input int nn, input int ee);
        int acc, p, c, w;
        m_err = 0; m_code = 0; m_used = 0; acc = 0;
        if (nn < 1 || nn > 16) begin
            m_err = 1; m_code = 3;
            return;
        end
        model_clear();
        while (acc < ee) begin
            p = int'(g_edges[m_used][3:0]);
            c = int'(g_edges[m_used][7:4]);
            w = int'(g_edges[m_used][11:8]);
            m_used++;
            if (p >= nn || c >= nn) begin
                m_err = 1; m_code = 1;
                return;
            end
            if (DIRECTED) begin
                if (m_nbr[p].size() == 8) begin m_err = 1; m_code = 2; return; end
                m_nbr[p].push_back(c); m_wgt[p].push_back(w);
            end else if (p != c) begin
                if (m_nbr[p].size() == 8 || m_nbr[c].size() == 8) begin
                    m_err = 1; m_code = 2; return;
                end
                m_nbr[p].push_back(c); m_wgt[p].push_back(w);
                m_nbr[c].push_back(p); m_wgt[c].push_back(w);
            end
            acc++;
        end
    endfunction

    task automatic run_build(input int nn, input int ee, input int mode, input int abort_at,
                             output int cyc, output int used, output int rdy1, output int rdy2,
                             output int busy1);
        int c; bit fin, v, rdy;
        used = 0; cyc = -1; fin = 0; rdy1 = -1; rdy2 = -1; busy1 = -1;
        @(posedge clk); #1;
        n = 5'(nn); e = 8'(ee); start = 1'b1; eif.edge_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; c = 1;
        while (!fin && c < 700) begin
            if (c == 1) begin rdy1 = int'(eif.edge_ready); busy1 = int'(busy); end
            if (c == 2) rdy2 = int'(eif.edge_ready);
            if (done) begin fin = 1; cyc = c; end
            else if (err) begin fin = 1; cyc = c; end
            else if (abort_at >= 0 && used == abort_at) fin = 1;
            else begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = ((c % 2) == 1);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                if (used >= g_edges.size()) v = 1'b0;
                rdy = eif.edge_ready;
                eif.edge_valid = v;
                eif.edge_data  = v ? g_edges[used] : 12'($urandom_range(0, 4095));
                @(posedge clk); #1;
                if (v && rdy) used++;
                eif.edge_valid = 1'b0;
                c++;
            end
        end
        if (!fin) chk("build_timeout", 0, 1);
    endtask

    task automatic check_outcome(input int x_err, input int x_code, input int x_cyc,
                                 input int cyc, input int used);
        chk("err", err, x_err);
        chk("err_code", err_code, x_code);
        chk("tables_valid", tables_valid, (x_err == 0) ? 1 : 0);
        chk("edge_ready_end", eif.edge_ready, 0);
        chk("busy_end", busy, 0);
        chk("consumed", used, m_used);
        if (x_cyc >= 0) chk("latency", cyc, x_cyc);
        if (x_err == 0) begin
            @(posedge clk); #1;
            chk("done_pulse_width", done, 0);
            chk("tables_valid_hold", tables_valid, 1);
        end
    endtask

    task automatic check_tables();
        for (int nd = 0; nd < 16; nd++) begin
            int sz;
            sz = m_nbr[nd].size();
            for (int ix = 0; ix <= sz; ix++) begin
                rd_node = 4'(nd); rd_idx = 4'(ix);
                @(posedge clk); #1;
                chk($sformatf("rd_deg n%0d i%0d", nd, ix), rd_deg, sz);
                chk($sformatf("rd_hit n%0d i%0d", nd, ix), rd_hit, (ix < sz) ? 1 : 0);
                chk($sformatf("rd_nbr n%0d i%0d", nd, ix), rd_nbr, (ix < sz) ? m_nbr[nd][ix] : 0);
                chk($sformatf("rd_wgt n%0d i%0d", nd, ix), rd_wgt, (ix < sz) ? m_wgt[nd][ix] : 0);
            end
        end
    endtask

    task automatic check_reset_vals();
        chk("rst edge_ready", eif.edge_ready, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst tables_valid", tables_valid, 0);
        chk("rst err", err, 0);
        chk("rst err_code", err_code, 0);
        chk("rst rd_nbr", rd_nbr, 0);
        chk("rst rd_wgt", rd_wgt, 0);
        chk("rst rd_deg", rd_deg, 0);
        chk("rst rd_hit", rd_hit, 0);
    endtask

    task automatic run_vec(input int i);
        int cyc, used, r1, r2, b1;
        g_edges.delete();
        for (int k = 0; k < 9 && k < vecs[i].e; k++) g_edges.push_back(vecs[i].ed[k]);
        model_build(vecs[i].n, vecs[i].e);
        run_build(vecs[i].n, vecs[i].e, vecs[i].mode, -1, cyc, used, r1, r2, b1);
        check_outcome(vecs[i].exp_err, vecs[i].exp_code, vecs[i].exp_cyc, cyc, used);
        if (vecs[i].exp_code != 3) begin
            chk($sformatf("v%0d ready_cycle1", i), r1, 0);
            chk($sformatf("v%0d busy_cycle1", i), b1, 1);
        end
        if (vecs[i].e > 0 && vecs[i].exp_code != 3)
            chk($sformatf("v%0d ready_cycle2", i), r2, 1);
        rd_node = 4'(vecs[i].sp_node); rd_idx = 4'(vecs[i].sp_idx);
        @(posedge clk); #1;
        chk($sformatf("v%0d spot nbr", i), rd_nbr, vecs[i].sp_nbr);
        chk($sformatf("v%0d spot wgt", i), rd_wgt, vecs[i].sp_wgt);
        chk($sformatf("v%0d spot deg", i), rd_deg, vecs[i].sp_deg);
        chk($sformatf("v%0d spot hit", i), rd_hit, vecs[i].sp_hit);
        check_tables();
    endtask

    initial begin
        int cyc, used, r1, r2, b1, nn, ee, mode, p, c;
        logic [8:0][11:0] plan_ed, star_ed, z_ed;
        plan_ed = '0; star_ed = '0; z_ed = '0;
        plan_ed[0] = mk(0, 1, 5); plan_ed[1] = mk(1, 2, 3); plan_ed[2] = mk(0, 3, 7);
        for (int k = 0; k < 9; k++) star_ed[k] = mk(0, k + 1, 1);

        //          n   e  md  edges    err code cyc  node idx nbr wgt deg hit
        vecs[0]  = '{4,  3, 0, plan_ed,  0, 0,  5,   0,  1,  3,  7,  2,  1};
        vecs[1]  = '{4,  3, 1, plan_ed,  0, 0,  8,   0,  0,  1,  5,  2,  1};
        z_ed[0]  = mk(0, 5, 1);
        vecs[2]  = '{4,  1, 0, z_ed,     1, 1,  3,   0,  0,  0,  0,  0,  0};
        vecs[3]  = '{4,  3, 0, plan_ed,  0, 0,  5,   0,  0,  1,  5,  2,  1};
        vecs[4]  = '{16, 9, 0, star_ed,  1, 2, 11,   0,  7,  8,  1,  8,  1};
        vecs[5]  = '{4,  0, 0, z_ed,     0, 0,  2,   3,  0,  0,  0,  0,  0};
        z_ed[0]  = mk(0, 1, 1);
        vecs[6]  = '{0,  1, 0, z_ed,     1, 3,  1,   3,  0,  0,  0,  0,  0};
        vecs[7]  = '{17, 1, 0, z_ed,     1, 3,  1,   3,  0,  0,  0,  0,  0};
        z_ed[0]  = mk(2, 2, 9); z_ed[1] = mk(1, 3, 4);
        vecs[8]  = '{4,  2, 0, z_ed,     0, 0,  4,   1,  0,  3,  4,  1,  1};
        z_ed     = '0; z_ed[0] = mk(3, 15, 2);
        vecs[9]  = '{15, 1, 0, z_ed,     1, 1,  3,   3,  0,  0,  0,  0,  0};
        z_ed[0]  = mk(15, 0, 6); z_ed[1] = mk(15, 15, 1);
        vecs[10] = '{16, 2, 0, z_ed,     0, 0,  4,  15,  0,  0,  6, DIRECTED ? 2 : 1, 1};

        eif.edge_valid = 1'b0; eif.edge_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b1;
        model_clear();

        for (int i = 0; i < 11; i++) run_vec(i);

        // Reset in the middle of a build, then rebuild from scratch.
        g_edges.delete();
        for (int k = 0; k < 3; k++) g_edges.push_back(plan_ed[k]);
        run_build(4, 3, 0, 2, cyc, used, r1, r2, b1);
        chk("mid_reset transfers", used, 2);
        reset = 1'b0;
        #2;
        check_reset_vals();
        @(posedge clk); #1;
        reset = 1'b1;
        model_clear();
        rd_node = 4'd0; rd_idx = 4'd0;
        @(posedge clk); #1;
        chk("post_reset deg node0", rd_deg, 0);
        run_vec(0);
        rd_node = 4'd1; rd_idx = 4'd0;
        @(posedge clk); #1;
        chk("rerun node1 idx0 nbr", rd_nbr, DIRECTED ? 2 : 0);
        chk("rerun node1 idx0 wgt", rd_wgt, DIRECTED ? 3 : 5);

        for (int it = 0; it < 25; it++) begin
            nn   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 16);
            ee   = $urandom_range(0, 14);
            mode = $urandom_range(0, 2);
            g_edges.delete();
            for (int k = 0; k < ee; k++) begin
                p = $urandom_range(0, nn - 1);
                c = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 15) : $urandom_range(0, nn - 1);
                g_edges.push_back(mk(p, c, $urandom_range(0, 15)));
            end
            model_build(nn, ee);
            run_build(nn, ee, mode, -1, cyc, used, r1, r2, b1);
            check_outcome(m_err, m_code,
                          (m_err != 0) ? ((mode == 0) ? m_used + 2 : -1)
                                       : ((mode == 0) ? ee + 2 : (mode == 1) ? 2 * ee + 2 : -1),
                          cyc, used);
            check_tables();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/edge_adj_builder.md
# edge_adj_builder

Upstream stage of the shortest-path engine. Accepts the graph as a stream of packed 12-bit edge words under a valid/ready handshake. Validates each edge and builds per-node adjacency lists (neighbour, weight) in registers. Exposes a registered random-access read port so the Dijkstra core can fetch neighbour k of node u without scanning the raw edge list.

## Interface
Parameters:
- NODES, 16, maximum node count; node ids are 0..NODES-1
- NODE_W, 4, node id width
- WGT_W, 4, edge weight width
- MAX_DEG, 8, maximum stored neighbours per node
- DEG_W, 4, degree counter width; must hold MAX_DEG

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  one-cycle pulse; latches n and e and begins a build
- n  in  NODE_W+1  node count, 1..NODES
- e  in  8  number of edges to accept, 0..255
- edge_valid  in  1  edge_data is valid
- edge_ready  out  1  builder accepts an edge this cycle
- edge_data  in  12  {weight[11:8], child[7:4], parent[3:0]}
- busy  out  1  high in CLEAR and LOAD
- done  out  1  one-cycle pulse when the tables become valid
- tables_valid  out  1  level; adjacency is complete and readable
- err  out  1  level; build aborted
- err_code  out  2  0 none, 1 node out of range, 2 degree overflow, 3 n out of range
- rd_node  in  NODE_W  read port node
- rd_idx  in  DEG_W  read port neighbour index
- rd_nbr  out  NODE_W  neighbour id, 1-cycle latency
- rd_wgt  out  WGT_W  edge weight, 1-cycle latency
- rd_deg  out  DEG_W  degree of rd_node, 1-cycle latency
- rd_hit  out  1  rd_idx < degree(rd_node), 1-cycle latency

## Operation
- States: IDLE, CLEAR, LOAD, DONE, ERR.
- **IDLE**: on start, latch n and e.
  - If n==0 or n>NODES, go to ERR with code 3.
  - Otherwise go to CLEAR.
- **CLEAR**: one cycle. All degree counters are zeroed and the accepted-edge counter is set to 0. Next state is LOAD, or DONE directly if e==0.
- **LOAD**: edge_ready=1.
  - An edge transfers on edge_valid && edge_ready.
  - If parent>=n or child>=n, go to ERR with code 1; no table write occurs.
  - If the insertion would push a node's degree past MAX_DEG, go to ERR with code 2; neither endpoint is written.
  - Otherwise write (child, weight) at slot deg[parent] and (parent, weight) at slot deg[child], and increment both degrees. Both writes happen in the same cycle.
  - Self-loop (parent==child): counted as accepted, no table write, no error.
  - Duplicate edges are stored as given.
  - After the e-th accepted edge, go to DONE.
- **DONE**: tables_valid=1; done pulses on the entry cycle only. A start pulse begins a new build.
- **ERR**: err=1; err_code is held. edge_ready=0 and tables_valid=0. A start pulse begins a new build.
- start received in CLEAR or LOAD is ignored.
- Read port is valid in any state; contents are meaningful only while tables_valid=1.
  - When rd_idx >= degree: rd_nbr=0, rd_wgt=0, rd_hit=0.
- Arithmetic: degree increments saturate by error, never wrap. The edge counter is 8-bit and compared with the latched e.

## Timing
- Reset values:
  - edge_ready=0, busy=0, done=0, tables_valid=0, err=0, err_code=0
  - rd_nbr=0, rd_wgt=0, rd_deg=0, rd_hit=0
  - all degrees 0; state IDLE
- Reset asserted mid-build: state returns to IDLE immediately and the tables are discarded.
- start at cycle t: CLEAR at t+1, edge_ready high from t+2.
- Throughput is 1 edge/cycle. Build latency with back-to-back edges is e+2 cycles from start to done.
- edge_ready drops in the cycle after the e-th transfer. It is registered and never depends combinationally on edge_valid.
- An error edge is consumed (handshake completes); edge_ready is low from the next cycle.
- Read port: address sampled at edge t, data valid after edge t (registered).

## Configuration
- ADJ_BUILDER_DIRECTED_EN
  - Defined: directed graph. Only parent's list receives (child, weight). Degree overflow is checked on parent only. Self-loops are stored like any edge.
  - Undefined: undirected behaviour as above.

## Structure
- Shared package dijkstra_pkg holds:
  - NODE_W, WGT_W, MAX_DEG, DEG_W
  - edge field offsets (PARENT_LSB=0, CHILD_LSB=4, WGT_LSB=8)
  - err_code constants
  - state enum
- Natural sub-module: adj_row, one node's list with write-at-degree, degree counter and indexed read. It is instantiated NODES times; the top holds the FSM, validation and read mux.

## Test plan
- n=4, e=3, edges (0,1,w5), (1,2,w3), (0,3,w7) -> done 5 cycles after start. Read node 0: deg 2, idx0 nbr1 w5, idx1 nbr3 w7. Read node 1: nbr0 w5, nbr2 w3.
- Same build with edge_valid toggling every other cycle -> identical tables; done 8 cycles after start.
- n=4, edge (0,5,w1) -> err=1, err_code=1, edge_ready=0, tables_valid=0. A new start recovers.
- n=16, nine edges (0,k,1) for k=1..9 -> ninth edge gives err_code=2. Node 0 keeps degree 8; node 9 degree 0.
- e=0 -> done 2 cycles after start, all degrees 0. Read node 3 idx 0 gives rd_hit=0.
- Reset pulsed after 2 of 3 edges -> all outputs at reset values. Re-run completes correctly; with ADJ_BUILDER_DIRECTED_EN, node 1's list is empty for edge (0,1,w5).
